ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 155 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/data/parity/stop and checks the device ACK.
// Define PS2_TX_TIMEOUT_EN to add a transfer watchdog that aborts a stalled transfer with TX_ERR.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       CLKBoard,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_START,
    input  logic       KEYSIG_CLK,
    input  logic       KEYSIG_DATA,
    output logic       KEYSIG_CLK_OE,
    output logic       KEYSIG_DATA_OE,
    output logic       TX_BUSY,
    output logic       TX_DONE,
    output logic       TX_ERR
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: INHIBIT_CYCLES and TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE} state_t;

    state_t             state;
    logic               clk_meta, clk_sync, clk_prev;
    logic               data_meta, data_sync;
    logic               clk_fall;
    logic [7:0]         tx_byte;
    logic               parity;
    logic [3:0]         bit_cnt;
    logic [INH_W-1:0]   inh_cnt;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [WD_W-1:0]    wd_cnt;
`endif

    // Idle PS/2 lines float high, so the synchronizers come out of reset at 1.
    always_ff @(posedge CLKBoard or posedge RESET) begin
        if (RESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= KEYSIG_CLK;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= KEYSIG_DATA;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;
    assign TX_BUSY  = (state != IDLE);

    always_ff @(posedge CLKBoard or posedge RESET) begin
        if (RESET) begin
            state          <= IDLE;
            KEYSIG_CLK_OE  <= 1'b0;
            KEYSIG_DATA_OE <= 1'b0;
            TX_DONE        <= 1'b0;
            TX_ERR         <= 1'b0;
            tx_byte        <= '0;
            parity         <= 1'b0;
            bit_cnt        <= '0;
            inh_cnt        <= '0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt         <= '0;
`endif
        end else begin
            TX_DONE <= 1'b0;
            TX_ERR  <= 1'b0;
            case (state)
                IDLE: begin
                    KEYSIG_CLK_OE  <= 1'b0;
                    KEYSIG_DATA_OE <= 1'b0;
                    if (TX_START) begin
                        tx_byte       <= TX_DATA;
                        parity        <= ~^TX_DATA;
                        inh_cnt       <= '0;
                        KEYSIG_CLK_OE <= 1'b1;
                        state         <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        KEYSIG_DATA_OE <= 1'b1;
                        state          <= START;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_cnt         <= '0;
`endif
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                end
                START: begin
                    KEYSIG_CLK_OE <= 1'b0;
                    bit_cnt       <= '0;
                    state         <= SEND;
                end
                // Edges 1-8 carry D0..D7, edge 9 the parity bit, edge 10 releases the line as the stop bit.
                SEND: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt < 4'd8) begin
                            KEYSIG_DATA_OE <= ~tx_byte[bit_cnt[2:0]];
                        end else if (bit_cnt == 4'd8) begin
                            KEYSIG_DATA_OE <= ~parity;
                        end else begin
                            KEYSIG_DATA_OE <= 1'b0;
                            state          <= ACK;
                        end
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        if (data_sync) begin
                            TX_ERR <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end
                end
                WAIT_IDLE: begin
                    if (clk_sync && data_sync) begin
                        TX_DONE <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            // Watchdog overrides whatever the FSM decided this cycle, so DONE and ERR stay exclusive.
            if (state inside {START, SEND, ACK, WAIT_IDLE}) begin
                if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    KEYSIG_CLK_OE  <= 1'b0;
                    KEYSIG_DATA_OE <= 1'b0;
                    TX_DONE        <= 1'b0;
                    TX_ERR         <= 1'b1;
                    state          <= IDLE;
                end else begin
                    wd_cnt <= wd_cnt + 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and captures them.
module tb_ps2_host_tx;

    localparam int INH  = 100;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    typedef struct {
        logic [7:0] data;
        bit         ack_ok;
        logic [8:0] exp_frame;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       kbd_clk, kbd_data;
    logic       clk_oe, data_oe, tx_busy, tx_done, tx_err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0, clk_rise = 0, data_rise = 0, clk_fall = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic prev_clk_oe = 1'b0, prev_data_oe = 1'b0;

    // Open-collector bus: either side may pull a line low.
    assign kbd_clk  = ~(clk_oe | dev_clk_low);
    assign kbd_data = ~(data_oe | dev_data_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLKBoard      (clk),
        .RESET         (rst),
        .TX_DATA       (tx_data),
        .TX_START      (tx_start),
        .KEYSIG_CLK    (kbd_clk),
        .KEYSIG_DATA   (kbd_data),
        .KEYSIG_CLK_OE (clk_oe),
        .KEYSIG_DATA_OE(data_oe),
        .TX_BUSY       (tx_busy),
        .TX_DONE       (tx_done),
        .TX_ERR        (tx_err)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (clk_oe && !prev_clk_oe)   clk_rise  <= cyc;
        if (data_oe && !prev_data_oe) data_rise <= cyc;
        if (!clk_oe && prev_clk_oe)   clk_fall  <= cyc;
        if (tx_done)                  done_cnt  <= done_cnt + 1;
        if (tx_err)                   err_cnt   <= err_cnt + 1;
        if (tx_done && tx_err)        both_cnt  <= both_cnt + 1;
        prev_clk_oe  <= clk_oe;
        prev_data_oe <= data_oe;
    end

    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic report_stall(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: wait bound expired, got busy=%0b expected completion", name, tx_busy);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: odd parity means the parity bit makes the total count of ones odd.
    function automatic logic [8:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {((ones % 2) == 0) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic apply_stimulus(input logic [7:0] data, input bit ack_ok, input int inject_at,
                                  input int reset_at, output logic [8:0] frame, output logic start_bit,
                                  output logic stop_bit, output int inh_len, output int rel_len,
                                  output logic busy_mid, output bit ok);
        int n;
        logic exp_oe;
        ok = 1'b1; frame = '0; start_bit = 1'b1; stop_bit = 1'b0;
        inh_len = 0; rel_len = 0; busy_mid = 1'b0;
        @(negedge clk);
        tx_data = data; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0; tx_data = 8'($urandom);
        n = 0;
        while (!(data_oe && !clk_oe) && n < INH + 50) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (!(data_oe && !clk_oe)) begin
            report_stall("start_phase");
            ok = 1'b0;
            return;
        end
        inh_len = data_rise - clk_rise;
        rel_len = clk_fall - data_rise;
        wait_cycles(HALF);
        start_bit = kbd_data;
        busy_mid = tx_busy;
        for (int e = 1; e <= 11; e++) begin
            if (e == 11 && ack_ok) begin
                dev_data_low = 1'b1;
                wait_cycles(4);
            end
            dev_clk_low = 1'b1;
            if (e == inject_at) begin
                tx_data = 8'hF4; tx_start = 1'b1;
                @(negedge clk);
                tx_start = 1'b0;
                wait_cycles(HALF - 1);
            end else begin
                wait_cycles(HALF);
            end
            if (e <= 9) frame[e-1] = kbd_data;
            else if (e == 10) stop_bit = kbd_data;
            if (e == reset_at) begin
                exp_oe = ~data[e-1];
                check_output("pre_reset_data_oe", {31'b0, data_oe}, {31'b0, exp_oe});
                #2 rst = 1'b1;
                #1;
                check_output("reset_clk_oe", {31'b0, clk_oe}, 32'd0);
                check_output("reset_data_oe", {31'b0, data_oe}, 32'd0);
                check_output("reset_busy", {31'b0, tx_busy}, 32'd0);
                check_output("reset_done_err", {30'b0, tx_done, tx_err}, 32'd0);
                dev_clk_low = 1'b0; dev_data_low = 1'b0;
                wait_cycles(3);
                rst = 1'b0;
                wait_cycles(3);
                ok = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
            wait_cycles(HALF);
            if (e == 11) dev_data_low = 1'b0;
        end
        n = 0;
        while (tx_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (tx_busy) begin
            report_stall("return_to_idle");
            ok = 1'b0;
        end
        wait_cycles(3);
        #1;
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] data, input bit ack_ok,
                                 input int inject_at, input logic [8:0] exp_frame,
                                 input bit exp_done, input bit exp_err);
        logic [8:0] frame;
        logic start_bit, stop_bit, busy_mid;
        int inh_len, rel_len, d0, e0;
        bit ok;
        d0 = done_cnt; e0 = err_cnt;
        apply_stimulus(data, ack_ok, inject_at, 0, frame, start_bit, stop_bit, inh_len, rel_len, busy_mid, ok);
        if (!ok) return;
        check_output({tag, "_inhibit_len"}, inh_len, INH);
        check_output({tag, "_clk_release"}, rel_len, 1);
        check_output({tag, "_busy_mid"}, {31'b0, busy_mid}, 32'd1);
        check_output({tag, "_start_bit"}, {31'b0, start_bit}, 32'd0);
        check_output({tag, "_frame"}, {23'b0, frame}, {23'b0, exp_frame});
        check_output({tag, "_stop_bit"}, {31'b0, stop_bit}, 32'd1);
        check_output({tag, "_done_pulses"}, done_cnt - d0, exp_done ? 1 : 0);
        check_output({tag, "_err_pulses"}, err_cnt - e0, exp_err ? 1 : 0);
        check_output({tag, "_idle_outputs"}, {29'b0, tx_busy, clk_oe, data_oe}, 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [7:0] rdata;
        bit rack;
        logic [8:0] frame;
        logic start_bit, stop_bit, busy_mid;
        int inh_len, rel_len;
        bit ok;

        vecs[0] = '{8'hED, 1'b1, 9'h1ED, 1'b1, 1'b0};
        vecs[1] = '{8'h02, 1'b1, 9'h002, 1'b1, 1'b0};
        vecs[2] = '{8'hF4, 1'b0, 9'h0F4, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 9'h100, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 9'h1FF, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 9'h080, 1'b1, 1'b0};

        wait_cycles(3);
        #1;
        check_output("reset_state", {27'b0, clk_oe, data_oe, tx_busy, tx_done, tx_err}, 32'd0);
        rst = 1'b0;
        wait_cycles(3);
        #1;
        check_output("post_reset_idle", {27'b0, clk_oe, data_oe, tx_busy, tx_done, tx_err}, 32'd0);

        for (int i = 0; i < 6; i++)
            run_and_check($sformatf("vec%0d", i), vecs[i].data, vecs[i].ack_ok, 0,
                          vecs[i].exp_frame, vecs[i].exp_done, vecs[i].exp_err);

        // A second request mid-frame must not disturb the byte being sent.
        run_and_check("ignore_start", 8'hED, 1'b1, 3, 9'h1ED, 1'b1, 1'b0);

        apply_stimulus(8'hED, 1'b1, 0, 4, frame, start_bit, stop_bit, inh_len, rel_len, busy_mid, ok);
        run_and_check("after_reset_ed", 8'hED, 1'b1, 0, 9'h1ED, 1'b1, 1'b0);
        apply_stimulus(8'h00, 1'b1, 0, 4, frame, start_bit, stop_bit, inh_len, rel_len, busy_mid, ok);
        run_and_check("after_reset_00", 8'h00, 1'b1, 0, 9'h100, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) begin
            rdata = 8'($urandom);
            rack  = ($urandom_range(0, 3) != 0);
            run_and_check($sformatf("rand%0d", i), rdata, rack, 0, ref_frame(rdata), rack, !rack);
        end

`ifdef PS2_TX_TIMEOUT_EN
        begin
            int n, k;
            @(negedge clk);
            tx_data = 8'hA5; tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
            n = 0;
            while (!data_oe && n < INH + 50) begin
                @(negedge clk);
                n++;
            end
            k = 0;
            while (!tx_err && k < TO + 50) begin
                @(negedge clk);
                k++;
            end
            check_output("timeout_latency", k, TO);
            check_output("timeout_lines_released", {30'b0, clk_oe, data_oe}, 32'd0);
            wait_cycles(2);
            #1;
            check_output("timeout_idle", {31'b0, tx_busy}, 32'd0);
        end
`endif

        check_output("done_err_overlap", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
